// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: FSM states, default idle word and SPI mode helpers shared by the SPI slave tx/rx paths
package spi_slave_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} spi_state_e;
  localparam logic [7:0] IDLE_WORD_DEF = 8'hFF;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  // SCLK level right after the edge on which the transmitter advances
  function automatic logic shift_level(input int cpol, input int cpha);
    return (cpol != 0) ^ (cpha != 0);
  endfunction
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: multi-flop synchronizer with registered level and one-cycle toggle strobe
module spi_edge_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic tog
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end
  assign q = sync[STAGES-1];
  assign tog = q ^ prev;
endmodule

// File: rtl/spi_slave_tx.sv
// spi_slave_tx: SPI slave transmitter popping a show-ahead FIFO onto MISO, MSB first.
// Optional SPI_TX_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module spi_slave_tx
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CPOL = 0,
  parameter int CPHA = 0,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'(IDLE_WORD_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs_n,
  input  logic                  spi_sclk,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rempty,
  output logic                  fifo_rinc,
  output logic                  tx_busy,
  output logic                  tx_underrun
`ifdef SPI_TX_UNDERRUN_CNT_EN
  , output logic [15:0]         tx_underrun_cnt
`endif
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  spi_state_e state;
  logic [DATA_WIDTH-1:0] shift_reg, load_word;
  logic [CW-1:0] bit_cnt;
  logic sclk_q, sclk_tog, cs_q, cs_tog, cs_fall, cs_rise;
  logic shift_edge, last, do_load, do_step, do_wrap;
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL != 0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_q), .tog(sclk_tog)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_q), .tog(cs_tog)
  );
  // CPHA=0 advances on the trailing edge, CPHA=1 on the leading edge; CPHA=1 loads on bit 0's leading edge
  always_comb begin
    cs_fall = cs_tog & ~cs_q;
    cs_rise = cs_tog & cs_q;
    shift_edge = ~cs_q & sclk_tog & (sclk_q == shift_level(CPOL, CPHA));
    last = bit_cnt == LAST;
    load_word = fifo_rempty ? IDLE_WORD : fifo_rdata;
    do_load = (CPHA != 0) ? shift_edge && (state == ST_LOAD || (state == ST_SHIFT && last))
                          : state == ST_LOAD;
    do_step = state == ST_SHIFT && shift_edge && !last;
    do_wrap = CPHA == 0 && state == ST_SHIFT && shift_edge && last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt <= '0;
      spi_miso <= 1'b1;
      spi_miso_oe <= 1'b0;
      fifo_rinc <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      spi_miso_oe <= ~cs_q;
      fifo_rinc <= do_load & ~fifo_rempty;
      tx_underrun <= do_load & fifo_rempty;
      if (do_load) begin
        shift_reg <= load_word;
        spi_miso <= load_word[DATA_WIDTH-1];
        bit_cnt <= '0;
        state <= ST_SHIFT;
      end else if (do_step) begin
        shift_reg <= shift_reg << 1;
        spi_miso <= shift_reg[DATA_WIDTH-2];
        bit_cnt <= bit_cnt + 1'b1;
      end else if (do_wrap || (state == ST_IDLE && cs_fall)) begin
        bit_cnt <= '0;
        state <= ST_LOAD;
      end
      // a frame end wins over everything; an in-flight pop above still completes
      if (cs_rise) begin
        state <= ST_IDLE;
        spi_miso <= 1'b1;
        bit_cnt <= '0;
      end
    end
  end
  assign tx_busy = state != ST_IDLE;
`ifdef SPI_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_underrun_cnt <= '0;
    else if (cs_fall) tx_underrun_cnt <= '0;
    else if (tx_underrun && tx_underrun_cnt != 16'hFFFF) tx_underrun_cnt <= tx_underrun_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_spi_slave_tx.sv
// tb_spi_slave_tx: directed bench for spi_slave_tx in modes 0, 1 and 3 against hand-computed bit streams
module tb_spi_slave_tx;
  logic clk = 1'b0, rst = 1'b1, cs_n = 1'b1, sclk = 1'b0;
  logic miso0, oe0, rinc0, busy0, und0, miso1, oe1, rinc1, busy1, und1, miso3, oe3, rinc3, busy3, und3;
  logic [7:0] mem [0:15];
  logic [3:0] wr = '0, rd = '0;
  logic [7:0] fifo_rdata0;
  logic fifo_rempty0;
  int checks = 0, errors = 0, pops0 = 0, unds0 = 0, bad_pops = 0;
`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [15:0] cnt0, cnt1, cnt3, cnt_snap;
`endif
  always #5 clk = ~clk;
  assign fifo_rdata0 = mem[rd];
  assign fifo_rempty0 = rd == wr;
  spi_slave_tx #(.CPOL(0), .CPHA(0)) u0 (
    .clk(clk), .rst(rst), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_miso(miso0), .spi_miso_oe(oe0),
    .fifo_rdata(fifo_rdata0), .fifo_rempty(fifo_rempty0), .fifo_rinc(rinc0), .tx_busy(busy0),
    .tx_underrun(und0)
`ifdef SPI_TX_UNDERRUN_CNT_EN
    , .tx_underrun_cnt(cnt0)
`endif
  );
  spi_slave_tx #(.CPOL(0), .CPHA(1)) u1 (
    .clk(clk), .rst(rst), .spi_cs_n(cs_n), .spi_sclk(sclk), .spi_miso(miso1), .spi_miso_oe(oe1),
    .fifo_rdata(8'h81), .fifo_rempty(1'b0), .fifo_rinc(rinc1), .tx_busy(busy1),
    .tx_underrun(und1)
`ifdef SPI_TX_UNDERRUN_CNT_EN
    , .tx_underrun_cnt(cnt1)
`endif
  );
  spi_slave_tx #(.CPOL(1), .CPHA(1)) u3 (
    .clk(clk), .rst(rst), .spi_cs_n(cs_n), .spi_sclk(~sclk), .spi_miso(miso3), .spi_miso_oe(oe3),
    .fifo_rdata(8'h81), .fifo_rempty(1'b0), .fifo_rinc(rinc3), .tx_busy(busy3),
    .tx_underrun(und3)
`ifdef SPI_TX_UNDERRUN_CNT_EN
    , .tx_underrun_cnt(cnt3)
`endif
  );
  always @(posedge clk) if (rinc0) rd <= rd + 4'd1;
  always @(negedge clk) begin
    if (rinc0) begin
      pops0++;
      if (fifo_rempty0) bad_pops++;
    end
    if (und0) unds0++;
  end

  typedef struct {
    logic [7:0] w0, w1;
    int nw, nbits;
    logic [15:0] exp0;
    int pops, unds;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] d);
    mem[wr] = d;
    wr = wr + 4'd1;
  endtask
  // Mode-0 bits are sampled before each rise, CPHA=1 bits before each fall; underruns snapshot before the last fall
  task automatic run_frame(input int n, output logic [15:0] b0, output logic [15:0] b1,
                           output logic [15:0] b3, output int und_snap);
    b0 = '0; b1 = '0; b3 = '0; und_snap = 0;
    cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < n; i++) begin
      b0 = {b0[14:0], miso0};
      sclk = 1'b1;
      wait_clk(8);
      b1 = {b1[14:0], miso1};
      b3 = {b3[14:0], miso3};
      und_snap = unds0;
`ifdef SPI_TX_UNDERRUN_CNT_EN
      cnt_snap = cnt0;
`endif
      sclk = 1'b0;
      wait_clk(8);
    end
  endtask

  initial begin
    logic [15:0] b0, b1, b3;
    int us, p_before, u_before;
    vecs[0] = '{8'hA5, 8'h00, 1, 8, 16'h00A5, 1, 0};
    vecs[1] = '{8'hA5, 8'h3C, 2, 16, 16'hA53C, 2, 0};
    vecs[2] = '{8'h00, 8'h00, 0, 8, 16'h00FF, 0, 1};
    vecs[3] = '{8'h96, 8'h00, 1, 8, 16'h0096, 1, 0};
    wait_clk(3);
    chk("rst_miso", 16'(miso0), 16'd1);
    chk("rst_oe", 16'(oe0), 16'd0);
    chk("rst_rinc", 16'(rinc0), 16'd0);
    chk("rst_busy", 16'(busy0), 16'd0);
    chk("rst_underrun", 16'(und0), 16'd0);
    rst = 1'b0;
    wait_clk(4);
    foreach (vecs[k]) begin
      if (vecs[k].nw > 0) push(vecs[k].w0);
      if (vecs[k].nw > 1) push(vecs[k].w1);
      p_before = pops0;
      u_before = unds0;
      run_frame(vecs[k].nbits, b0, b1, b3, us);
      chk($sformatf("v%0d_mode0_bits", k), b0, vecs[k].exp0);
      chk($sformatf("v%0d_mode1_bits", k), b1, vecs[k].nbits == 16 ? 16'h8181 : 16'h0081);
      chk($sformatf("v%0d_mode3_bits", k), b3, vecs[k].nbits == 16 ? 16'h8181 : 16'h0081);
      chk($sformatf("v%0d_underruns", k), 16'(us - u_before), 16'(vecs[k].unds));
`ifdef SPI_TX_UNDERRUN_CNT_EN
      chk($sformatf("v%0d_underrun_cnt", k), cnt_snap, 16'(vecs[k].unds));
`endif
      chk($sformatf("v%0d_oe_in_frame", k), 16'(oe0), 16'd1);
      chk($sformatf("v%0d_busy_in_frame", k), 16'(busy0), 16'd1);
      cs_n = 1'b1;
      wait_clk(4);
      chk($sformatf("v%0d_pops", k), 16'(pops0 - p_before), 16'(vecs[k].pops));
      chk($sformatf("v%0d_oe_after", k), 16'(oe0), 16'd0);
      chk($sformatf("v%0d_busy_after", k), 16'(busy0), 16'd0);
      chk($sformatf("v%0d_miso_after", k), 16'(miso0), 16'd1);
      wait_clk(8);
    end
    // abort after 3 bits of 5A: the rest is dropped and the next frame starts on 77
    push(8'h5A);
    push(8'h77);
    p_before = pops0;
    run_frame(3, b0, b1, b3, us);
    chk("abort_partial_bits", b0, 16'h0002);
    cs_n = 1'b1;
    wait_clk(2);
    chk("abort_oe_not_early", 16'(oe0), 16'd1);
    wait_clk(1);
    chk("abort_oe_off", 16'(oe0), 16'd0);
    chk("abort_miso_idle", 16'(miso0), 16'd1);
    wait_clk(8);
    run_frame(8, b0, b1, b3, us);
    chk("abort_next_word", b0, 16'h0077);
    cs_n = 1'b1;
    wait_clk(4);
    chk("abort_pops", 16'(pops0 - p_before), 16'd2);
    wait_clk(8);
    // asynchronous reset in the middle of a word
    push(8'hC3);
    push(8'h3C);
    p_before = pops0;
    cs_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 2; i++) begin
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      wait_clk(8);
    end
    sclk = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    #1;
    chk("midrst_miso", 16'(miso0), 16'd1);
    chk("midrst_oe", 16'(oe0), 16'd0);
    chk("midrst_rinc", 16'(rinc0), 16'd0);
    chk("midrst_busy", 16'(busy0), 16'd0);
    chk("midrst_underrun", 16'(und0), 16'd0);
    chk("midrst_oe_mode1", 16'(oe1), 16'd0);
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      wait_clk(8);
    end
    chk("midrst_pops_stop", 16'(pops0 - p_before), 16'd1);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    chk("postrst_busy", 16'(busy0), 16'd0);
    chk("postrst_no_pop", 16'(pops0 - p_before), 16'd1);
    chk("no_pop_when_empty", 16'(bad_pops), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
